// File: rtl/ddr5_cmd_scheduler_if.sv
// Host request / PHY command bundle for the DDR5 command scheduler.
// Latency: wires only; no storage in the interface.
// Backpressure: req_ready gates the request side; the command side has no stall.
//
// Signals
//   req_valid/req_ready/req_write/req_bank/req_row/req_col : host request handshake
//   cmd_valid/cmd_code/cmd_bank/cmd_row/cmd_col            : PHY command strobe
//   rd_data_valid, refresh_active, queue_count             : status
// Modports: master = request producer / command consumer, slave = scheduler.
interface ddr5_cmd_scheduler_if #(
    parameter int NUM_BANKS   = 4,
    parameter int ROW_WIDTH   = 16,
    parameter int COL_WIDTH   = 10,
    parameter int QUEUE_DEPTH = 8
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [BANK_W-1:0]    req_bank;
    logic [ROW_WIDTH-1:0] req_row;
    logic [COL_WIDTH-1:0] req_col;

    logic                 cmd_valid;
    logic [2:0]           cmd_code;
    logic [BANK_W-1:0]    cmd_bank;
    logic [ROW_WIDTH-1:0] cmd_row;
    logic [COL_WIDTH-1:0] cmd_col;

    logic                 rd_data_valid;
    logic                 refresh_active;
    logic [CNT_W-1:0]     queue_count;

    modport master (
        output req_valid, req_write, req_bank, req_row, req_col,
        input  req_ready,
        input  cmd_valid, cmd_code, cmd_bank, cmd_row, cmd_col,
        input  rd_data_valid, refresh_active, queue_count
    );

    modport slave (
        input  req_valid, req_write, req_bank, req_row, req_col,
        output req_ready,
        output cmd_valid, cmd_code, cmd_bank, cmd_row, cmd_col,
        output rd_data_valid, refresh_active, queue_count
    );
endinterface

// File: rtl/ddr5_cmd_scheduler.sv
// Multi-bank DDR5 command scheduler: in-order request FIFO, open-page bank tracking, periodic refresh.
// Latency: a request reaches the PHY no earlier than one cycle after acceptance; commands are registered.
// Backpressure: req_ready (registered, = FIFO not full) stalls the host; the PHY side never stalls.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   bus (slave)    : request handshake in, command strobe out, rd_data_valid / refresh_active / queue_count
module ddr5_cmd_scheduler #(
    parameter int NUM_BANKS   = 4,
    parameter int ROW_WIDTH   = 16,
    parameter int COL_WIDTH   = 10,
    parameter int QUEUE_DEPTH = 8,
    parameter int T_RCD       = 14,
    parameter int T_RP        = 14,
    parameter int T_CCD       = 4,
    parameter int T_RFC       = 295,
    parameter int T_REFI      = 3900,
    parameter int CAS_LATENCY = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    ddr5_cmd_scheduler_if.slave   bus
);
    localparam int BANK_W  = $clog2(NUM_BANKS);
    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int RC_W    = $clog2(T_REFI);
    localparam int T_MAX_A = (T_RCD > T_RP)    ? T_RCD : T_RP;
    localparam int T_MAX_B = (T_CCD > T_RFC)   ? T_CCD : T_RFC;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int TMR_W   = $clog2(T_MAX + 1);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_PREA = 3'd5;
    localparam logic [2:0] CMD_REF  = 3'd6;

    typedef struct packed {
        logic                 wr;
        logic [BANK_W-1:0]    bank;
        logic [ROW_WIDTH-1:0] row;
        logic [COL_WIDTH-1:0] col;
    } req_t;

    // request FIFO
    req_t             fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] q_count_nxt;
    logic             req_ready_q;
    logic             push;
    logic             pop;
    req_t             head;
    req_t             in_req;

    // bank and timing state
    logic [NUM_BANKS-1:0] bank_open;
    logic [ROW_WIDTH-1:0] open_row [NUM_BANKS];
    logic [TMR_W-1:0]     timer;
    logic [TMR_W-1:0]     tmr_load;
    logic [RC_W-1:0]      ref_cnt;
    logic                 ref_wrap;
    logic                 ref_pend;
    logic                 ref_busy;

    // command decision and registered outputs
    logic [2:0]           nxt_code;
    logic [BANK_W-1:0]    nxt_bank;
    logic [ROW_WIDTH-1:0] nxt_row;
    logic [COL_WIDTH-1:0] nxt_col;
    logic                 issue;
    logic                 cmd_valid_q;
    logic [2:0]           cmd_code_q;
    logic [BANK_W-1:0]    cmd_bank_q;
    logic [ROW_WIDTH-1:0] cmd_row_q;
    logic [COL_WIDTH-1:0] cmd_col_q;

    logic                   rd_now;
    logic [CAS_LATENCY-1:0] rd_sr;
    logic [CAS_LATENCY:0]   rd_sr_ext;

    assign in_req   = '{wr: bus.req_write, bank: bus.req_bank, row: bus.req_row, col: bus.req_col};
    assign head     = fifo_mem[rd_ptr];
    assign push     = bus.req_valid && req_ready_q;
    assign ref_wrap = (ref_cnt == RC_W'(T_REFI - 1));
    assign issue    = (nxt_code != CMD_NOP);

    // The decision is registered onto the command port on the same edge that
    // loads the timer, so the timer holds (spacing - 1): the next decision
    // happens when it reaches 0 and its strobe lands exactly 'spacing' cycles
    // after the previous strobe.
    always_comb begin
        nxt_code = CMD_NOP;
        nxt_bank = '0;
        nxt_row  = '0;
        nxt_col  = '0;
        tmr_load = '0;
        pop      = 1'b0;
        if (timer == '0) begin
            if (ref_pend && (|bank_open)) begin
                nxt_code = CMD_PREA;
                tmr_load = TMR_W'(T_RP - 1);
            end else if (ref_pend) begin
                nxt_code = CMD_REF;
                tmr_load = TMR_W'(T_RFC - 1);
            end else if (q_count != '0) begin
                nxt_bank = head.bank;
                if (!bank_open[head.bank]) begin
                    nxt_code = CMD_ACT;
                    nxt_row  = head.row;
                    tmr_load = TMR_W'(T_RCD - 1);
                end else if (open_row[head.bank] == head.row) begin
                    nxt_code = head.wr ? CMD_WR : CMD_RD;
                    nxt_col  = head.col;
                    pop      = 1'b1;
                    tmr_load = TMR_W'(T_CCD - 1);
                end else begin
                    nxt_code = CMD_PRE;
                    tmr_load = TMR_W'(T_RP - 1);
                end
            end
        end
    end

    always_comb begin
        q_count_nxt = q_count;
        if (push && !pop)
            q_count_nxt = q_count + CNT_W'(1);
        else if (!push && pop)
            q_count_nxt = q_count - CNT_W'(1);
    end

    assign rd_now    = cmd_valid_q && (cmd_code_q == CMD_RD);
    assign rd_sr_ext = {rd_sr, rd_now};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_count     <= '0;
            req_ready_q <= 1'b1;
            bank_open   <= '0;
            timer       <= '0;
            ref_cnt     <= '0;
            ref_pend    <= 1'b0;
            ref_busy    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= CMD_NOP;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            rd_sr       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            q_count     <= q_count_nxt;
            req_ready_q <= (q_count_nxt != CNT_W'(QUEUE_DEPTH));

            cmd_valid_q <= issue;
            cmd_code_q  <= nxt_code;
            cmd_bank_q  <= nxt_bank;
            cmd_row_q   <= nxt_row;
            cmd_col_q   <= nxt_col;

            if (issue)
                timer <= tmr_load;
            else if (timer != '0)
                timer <= timer - TMR_W'(1);

            case (nxt_code)
                CMD_PREA: bank_open <= '0;
                CMD_ACT:  bank_open[nxt_bank] <= 1'b1;
                CMD_PRE:  bank_open[nxt_bank] <= 1'b0;
                default:  ;
            endcase

            // A fresh interval expiry wins over the REF that clears the flag.
            ref_cnt  <= ref_wrap ? '0 : ref_cnt + RC_W'(1);
            ref_pend <= ref_wrap || (ref_pend && (nxt_code != CMD_REF));

            // Held from the REF strobe through the last cycle of tRFC.
            if (nxt_code == CMD_REF)
                ref_busy <= 1'b1;
            else if (timer == '0)
                ref_busy <= 1'b0;

            rd_sr <= rd_sr_ext[CAS_LATENCY-1:0];
        end
    end

    // Storage without reset: contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= in_req;
        if (nxt_code == CMD_ACT)
            open_row[nxt_bank] <= nxt_row;
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.cmd_valid      = cmd_valid_q;
    assign bus.cmd_code       = cmd_code_q;
    assign bus.cmd_bank       = cmd_bank_q;
    assign bus.cmd_row        = cmd_row_q;
    assign bus.cmd_col        = cmd_col_q;
    assign bus.rd_data_valid  = rd_sr[CAS_LATENCY-1];
    assign bus.refresh_active = ref_pend || ref_busy;
    assign bus.queue_count    = q_count;
endmodule

// File: tb/tb_ddr5_cmd_scheduler.sv
// Testbench for ddr5_cmd_scheduler: directed vector table, corner sequences, random vs. reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: the model tracks req_ready from its own queue occupancy.
module tb_ddr5_cmd_scheduler;
    localparam int NB = 4, RW = 16, CW = 10, QD = 4;
    localparam int TRCD = 3, TRP = 2, TCCD = 2, TRFC = 5, TREFI = 40, CL = 4;
    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3;
    localparam logic [2:0] PRE = 3'd4, PREA = 3'd5, REF = 3'd6;

    typedef logic [37:0] ovec_t;
    typedef struct { int cyc; logic v; logic w; int b; int r; int c; ovec_t exp; } vec_t;
    typedef struct { logic wr; int bank; int row; int col; } mreq_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    ddr5_cmd_scheduler_if #(.NUM_BANKS(NB), .ROW_WIDTH(RW), .COL_WIDTH(CW), .QUEUE_DEPTH(QD)) bus();

    ddr5_cmd_scheduler #(
        .NUM_BANKS(NB), .ROW_WIDTH(RW), .COL_WIDTH(CW), .QUEUE_DEPTH(QD),
        .T_RCD(TRCD), .T_RP(TRP), .T_CCD(TCCD), .T_RFC(TRFC), .T_REFI(TREFI), .CAS_LATENCY(CL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {valid, code, bank, row, col, rd_data_valid, refresh_active, req_ready, queue_count}
    function automatic ovec_t mk(logic v, logic [2:0] code, int bank, int row, int col,
                                 logic rdv, logic rf, int cnt);
        return {v, code, 2'(bank), 16'(row), 10'(col), rdv, rf, (cnt != QD), 3'(cnt)};
    endfunction

    function automatic ovec_t act_vec();
        return {bus.cmd_valid, bus.cmd_code, bus.cmd_bank, bus.cmd_row, bus.cmd_col,
                bus.rd_data_valid, bus.refresh_active, bus.req_ready, bus.queue_count};
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input int b, input int r, input int c);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_bank  = 2'(b);
        bus.req_row   = 16'(r);
        bus.req_col   = 10'(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after reset release (refresh counter = 0).
    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic tv(input int cyc, input logic v, input logic w, input int b, input int r,
                      input int c, input ovec_t e);
        vec_t t;
        t.cyc = cyc; t.v = v; t.w = w; t.b = b; t.r = r; t.c = c; t.exp = e;
        tbl.push_back(t);
    endtask

    initial begin
        int p;
        int mopen[NB];
        mreq_t mq[$];
        mreq_t h;
        int rd_due[$];
        int next_ok, ref_lo, ref_hi;
        bit mpend, mready, any_open;
        logic v, w, ev, erdv, eref;
        int b, r, col, eb, er, ecol;
        logic [2:0] ec;

        // Expected outputs are those seen in cycle cyc+1.
        tv(0,  1, 0, 1, 5, 7, mk(0, NOP,  0, 0, 0, 0, 0, 1));
        tv(1,  1, 0, 1, 5, 9, mk(1, ACT,  1, 5, 0, 0, 0, 2));
        tv(3,  0, 0, 0, 0, 0, mk(0, NOP,  0, 0, 0, 0, 0, 2));
        tv(4,  0, 0, 0, 0, 0, mk(1, RD,   1, 0, 7, 0, 0, 1));
        tv(5,  0, 0, 0, 0, 0, mk(0, NOP,  0, 0, 0, 0, 0, 1));
        tv(6,  0, 0, 0, 0, 0, mk(1, RD,   1, 0, 9, 0, 0, 0));
        tv(7,  0, 0, 0, 0, 0, mk(0, NOP,  0, 0, 0, 0, 0, 0));
        tv(8,  0, 0, 0, 0, 0, mk(0, NOP,  0, 0, 0, 1, 0, 0));
        tv(9,  0, 0, 0, 0, 0, mk(0, NOP,  0, 0, 0, 0, 0, 0));
        tv(10, 0, 0, 0, 0, 0, mk(0, NOP,  0, 0, 0, 1, 0, 0));
        tv(11, 1, 1, 1, 6, 3, mk(0, NOP,  0, 0, 0, 0, 0, 1));
        tv(12, 0, 0, 0, 0, 0, mk(1, PRE,  1, 0, 0, 0, 0, 1));
        tv(13, 0, 0, 0, 0, 0, mk(0, NOP,  0, 0, 0, 0, 0, 1));
        tv(14, 0, 0, 0, 0, 0, mk(1, ACT,  1, 6, 0, 0, 0, 1));
        tv(16, 0, 0, 0, 0, 0, mk(0, NOP,  0, 0, 0, 0, 0, 1));
        tv(17, 0, 0, 0, 0, 0, mk(1, WR,   1, 0, 3, 0, 0, 0));
        tv(38, 0, 0, 0, 0, 0, mk(0, NOP,  0, 0, 0, 0, 0, 0));
        tv(39, 0, 0, 0, 0, 0, mk(0, NOP,  0, 0, 0, 0, 1, 0));
        tv(40, 0, 0, 0, 0, 0, mk(1, PREA, 0, 0, 0, 0, 1, 0));
        tv(41, 1, 0, 2, 1, 0, mk(0, NOP,  0, 0, 0, 0, 1, 1));
        tv(42, 0, 0, 0, 0, 0, mk(1, REF,  0, 0, 0, 0, 1, 1));
        tv(46, 0, 0, 0, 0, 0, mk(0, NOP,  0, 0, 0, 0, 1, 1));
        tv(47, 0, 0, 0, 0, 0, mk(1, ACT,  2, 1, 0, 0, 0, 1));

        // Reset state, then reads / row miss / refresh from the table.
        do_reset();
        check("reset_state", act_vec(), mk(0, NOP, 0, 0, 0, 0, 0, 0));
        p = 0;
        for (int c = 0; c < 50; c++) begin
            if (p < tbl.size() && tbl[p].cyc == c) begin
                drive(tbl[p].v, tbl[p].w, tbl[p].b, tbl[p].r, tbl[p].c);
                tick();
                check($sformatf("vec_c%0d", c), act_vec(), tbl[p].exp);
                p++;
            end else begin
                drive(0, 0, 0, 0, 0);
                tick();
                check($sformatf("idle_c%0d", c), {bus.cmd_valid, bus.cmd_code}, 0);
            end
        end

        // Reset between ACT (cycle 48) and its RD (due cycle 51).
        reset = 1'b1;
        tick();
        check("mid_reset", act_vec(), mk(0, NOP, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("post_reset_c%0d", c), act_vec(), mk(0, NOP, 0, 0, 0, 0, 0, 0));
        end
        drive(1, 0, 2, 1, 4);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        check("banks_closed_after_reset", act_vec(), mk(1, ACT, 2, 1, 0, 0, 0, 1));

        // FIFO fill with req_valid held.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1, 0, 0, 2, c);
            tick();
            if (c == 3) check("full_cnt4_rdy0", act_vec(), mk(0, NOP, 0, 0, 0, 0, 0, 4));
            if (c == 4) check("pop_at_full",    act_vec(), mk(1, RD, 0, 0, 0, 0, 0, 3));
            if (c == 5) check("refill_to_4",    {bus.req_ready, bus.queue_count}, {1'b0, 3'd4});
        end
        drive(0, 0, 0, 0, 0);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < NB; i++) mopen[i] = -1;
        mq.delete();
        rd_due.delete();
        next_ok = 0; ref_lo = -1; ref_hi = -2; mpend = 0; mready = 1;
        for (int c = 0; c < 1500; c++) begin
            v = ($urandom_range(0, 2) != 0);
            w = 1'($urandom_range(0, 1));
            b = $urandom_range(0, NB - 1);
            r = $urandom_range(0, 2);
            col = $urandom_range(0, 1023);
            drive(v, w, b, r, col);

            ev = 0; ec = NOP; eb = 0; er = 0; ecol = 0;
            if (c >= next_ok) begin
                any_open = 0;
                for (int i = 0; i < NB; i++) if (mopen[i] >= 0) any_open = 1;
                if (mpend && any_open) begin
                    ev = 1; ec = PREA;
                    for (int i = 0; i < NB; i++) mopen[i] = -1;
                    next_ok = c + TRP;
                end else if (mpend) begin
                    ev = 1; ec = REF; mpend = 0;
                    ref_lo = c + 1; ref_hi = c + TRFC;
                    next_ok = c + TRFC;
                end else if (mq.size() != 0) begin
                    h = mq[0];
                    ev = 1; eb = h.bank;
                    if (mopen[h.bank] < 0) begin
                        ec = ACT; er = h.row; mopen[h.bank] = h.row;
                        next_ok = c + TRCD;
                    end else if (mopen[h.bank] == h.row) begin
                        ec = h.wr ? WR : RD; ecol = h.col;
                        void'(mq.pop_front());
                        if (!h.wr) rd_due.push_back(c + 1 + CL);
                        next_ok = c + TCCD;
                    end else begin
                        ec = PRE; mopen[h.bank] = -1;
                        next_ok = c + TRP;
                    end
                end
            end
            if (v && mready) begin
                h.wr = w; h.bank = b; h.row = r; h.col = col;
                mq.push_back(h);
            end
            if (c % TREFI == TREFI - 1) mpend = 1;
            mready = (mq.size() < QD);
            erdv = 0;
            if (rd_due.size() != 0 && rd_due[0] == c + 1) begin
                erdv = 1;
                void'(rd_due.pop_front());
            end
            eref = mpend || (c + 1 >= ref_lo && c + 1 <= ref_hi);

            tick();
            check($sformatf("rand_c%0d", c), act_vec(),
                  mk(ev, ec, eb, er, ecol, erdv, eref, mq.size()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
